qp_sequencer: RTL and testbench

Per-macroblock quantiser-parameter controller for the H.264 baseline decoder. It sits between the slice/MB syntax parsers and the inverse-quantisation stage. It holds the running QP predictor across macroblocks and applies each `mb_qp_delta` with modulo-52 wrap. It derives the luma and chroma QPs through a registered pipeline and presents them to inverse quantisation on a valid/ready handshake.

---
 rtl/qp_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_qp_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/qp_sequencer.sv
// qp_sequencer: per-macroblock QP predictor with luma/chroma QP derivation.
// Macro QP_SECOND_CHROMA_OFFSET_EN adds an independent Cr offset and map path.
module qp_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic       slice_start,
    input  logic [5:0] slice_qp,
    input  logic [4:0] chroma_qp_index_offset,
`ifdef QP_SECOND_CHROMA_OFFSET_EN
    input  logic [4:0] second_chroma_qp_index_offset,
`endif
    input  logic       mb_valid,
    input  logic       mb_has_delta,
    input  logic [6:0] mb_qp_delta,
    output logic       mb_ready,
    output logic       qp_valid,
    input  logic       qp_ready,
    output logic [5:0] QPy,
    output logic [5:0] QPc_cb,
    output logic [5:0] QPc_cr,
    output logic       delta_err,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUM  = 2'd1,
        MAP  = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [5:0] pred_q;
    logic [6:0] delta_q;
    logic [5:0] qpy_q;
    logic [5:0] qpc_cb_q;
    logic       err_q;

    logic              accept;
    logic signed [6:0] delta_s;
    logic              delta_legal;
    logic              delta_bad;
    logic [6:0]        delta_eff;
    logic signed [7:0] sum_raw;
    logic signed [7:0] sum_adj;
    logic [5:0]        sum_wrap;
    logic [5:0]        map_cb;

    // qPI = clip3(0, 51, QPy + signed offset)
    function automatic logic [5:0] clip_qpi(
        input logic [5:0] qpy,
        input logic [4:0] off
    );
        logic signed [7:0] t;
        t = $signed({2'b00, qpy}) + $signed({{3{off[4]}}, off});
        if (t < 8'sd0) begin
            clip_qpi = 6'd0;
        end else if (t > 8'sd51) begin
            clip_qpi = 6'd51;
        end else begin
            clip_qpi = t[5:0];
        end
    endfunction

    // qPI to QPc table; identity below 30
    function automatic logic [5:0] chroma_map(input logic [5:0] qpi);
        logic [5:0] r;
        if (qpi < 6'd30) begin
            r = qpi;
        end else begin
            case (qpi)
                6'd30:                r = 6'd29;
                6'd31:                r = 6'd30;
                6'd32:                r = 6'd31;
                6'd33, 6'd34:         r = 6'd32;
                6'd35:                r = 6'd33;
                6'd36, 6'd37:         r = 6'd34;
                6'd38, 6'd39:         r = 6'd35;
                6'd40, 6'd41:         r = 6'd36;
                6'd42, 6'd43, 6'd44:  r = 6'd37;
                6'd45, 6'd46, 6'd47:  r = 6'd38;
                default:              r = 6'd39;
            endcase
        end
        chroma_map = r;
    endfunction

    // A slice_start in the same cycle blocks the request.
    assign accept = (state_q == IDLE) & mb_valid & ~slice_start;

    // Effective delta: absent or out-of-range deltas become zero.
    always_comb begin
        delta_s     = $signed(mb_qp_delta);
        delta_legal = (delta_s >= -7'sd26) && (delta_s <= 7'sd25);
        delta_bad   = mb_has_delta & ~delta_legal;
        delta_eff   = 7'd0;
        if (mb_has_delta && delta_legal) begin
            delta_eff = mb_qp_delta;
        end
    end

    // Predictor update with modulo-52 wrap.
    always_comb begin
        sum_raw = $signed({2'b00, pred_q}) + $signed({delta_q[6], delta_q});
        sum_adj = sum_raw;
        if (sum_raw < 8'sd0) begin
            sum_adj = sum_raw + 8'sd52;
        end else if (sum_raw > 8'sd51) begin
            sum_adj = sum_raw - 8'sd52;
        end
        sum_wrap = sum_adj[5:0];
    end

    // Cb mapping path from the registered luma QP.
    always_comb begin
        map_cb = chroma_map(clip_qpi(qpy_q, chroma_qp_index_offset));
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; slice_start overrides everything.
    always_comb begin
        state_d = state_q;
        if (slice_start) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: if (mb_valid) state_d = SUM;
                SUM:  state_d = MAP;
                MAP:  state_d = HOLD;
                HOLD: if (qp_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Handshake and status flags decoded from the state register.
    always_comb begin
        mb_ready = (state_q == IDLE);
        qp_valid = (state_q == HOLD);
        busy     = (state_q != IDLE);
    end

    // Predictor, delta, luma QP, Cb QP and sticky error registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pred_q   <= 6'd26;
            delta_q  <= 7'd0;
            qpy_q    <= 6'd0;
            qpc_cb_q <= 6'd0;
            err_q    <= 1'b0;
        end else if (slice_start) begin
            pred_q <= slice_qp;
            err_q  <= 1'b0;
        end else begin
            if (accept) begin
                delta_q <= delta_eff;
                if (delta_bad) begin
                    err_q <= 1'b1;
                end
            end
            if (state_q == SUM) begin
                pred_q <= sum_wrap;
                qpy_q  <= sum_wrap;
            end
            if (state_q == MAP) begin
                qpc_cb_q <= map_cb;
            end
        end
    end

`ifdef QP_SECOND_CHROMA_OFFSET_EN
    logic [5:0] qpc_cr_q;
    logic [5:0] map_cr;

    // Independent Cr mapping path.
    always_comb begin
        map_cr = chroma_map(clip_qpi(qpy_q, second_chroma_qp_index_offset));
    end

    // Cr QP register, loaded alongside Cb.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            qpc_cr_q <= 6'd0;
        end else if (!slice_start && state_q == MAP) begin
            qpc_cr_q <= map_cr;
        end
    end

    assign QPc_cr = qpc_cr_q;
`else
    assign QPc_cr = qpc_cb_q;
`endif

    assign QPy       = qpy_q;
    assign QPc_cb    = qpc_cb_q;
    assign delta_err = err_q;

endmodule

// File: tb/tb_qp_sequencer.sv
// tb_qp_sequencer: directed checks of qp_sequencer.
// Expected values are hand-computed per step.
module tb_qp_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       slice_start = 1'b0;
    logic [5:0] slice_qp = 6'd0;
    logic [4:0] cb_off = 5'd0;
`ifdef QP_SECOND_CHROMA_OFFSET_EN
    logic [4:0] cr_off = 5'd0;
`endif
    logic       mb_valid = 1'b0;
    logic       mb_has_delta = 1'b0;
    logic [6:0] mb_qp_delta = 7'd0;
    logic       mb_ready;
    logic       qp_valid;
    logic       qp_ready = 1'b1;
    logic [5:0] QPy;
    logic [5:0] QPc_cb;
    logic [5:0] QPc_cr;
    logic       delta_err;
    logic       busy;

    int checks = 0;
    int errors = 0;

    qp_sequencer dut (
        .clk                           (clk),
        .reset                         (reset),
        .slice_start                   (slice_start),
        .slice_qp                      (slice_qp),
        .chroma_qp_index_offset        (cb_off),
`ifdef QP_SECOND_CHROMA_OFFSET_EN
        .second_chroma_qp_index_offset (cr_off),
`endif
        .mb_valid                      (mb_valid),
        .mb_has_delta                  (mb_has_delta),
        .mb_qp_delta                   (mb_qp_delta),
        .mb_ready                      (mb_ready),
        .qp_valid                      (qp_valid),
        .qp_ready                      (qp_ready),
        .QPy                           (QPy),
        .QPc_cb                        (QPc_cb),
        .QPc_cr                        (QPc_cr),
        .delta_err                     (delta_err),
        .busy                          (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic new_slice(input logic [5:0] q, input logic [4:0] off);
        slice_qp    = q;
        cb_off      = off;
`ifdef QP_SECOND_CHROMA_OFFSET_EN
        cr_off      = off;
`endif
        slice_start = 1'b1;
        tick();
        slice_start = 1'b0;
    endtask

    // Accept one MB and advance to HOLD.
    task automatic mb_to_hold(input logic has, input logic [6:0] d);
        mb_has_delta = has;
        mb_qp_delta  = d;
        mb_valid     = 1'b1;
        tick();
        mb_valid = 1'b0;
        tick();
        tick();
    endtask

    // Check HOLD outputs, then leave HOLD with qp_ready high.
    task automatic hold_chk(input string tag, input logic [5:0] y,
                            input logic [5:0] cb);
        chk({tag, "_valid"}, {7'd0, qp_valid}, 8'd1);
        chk({tag, "_qpy"}, {2'd0, QPy}, {2'd0, y});
        chk({tag, "_cb"}, {2'd0, QPc_cb}, {2'd0, cb});
        chk({tag, "_cr"}, {2'd0, QPc_cr}, {2'd0, cb});
        qp_ready = 1'b1;
        tick();
    endtask

    initial begin
        // Reset values
        #12;
        chk("rst_qpy", {2'd0, QPy}, 8'd0);
        chk("rst_cb", {2'd0, QPc_cb}, 8'd0);
        chk("rst_cr", {2'd0, QPc_cr}, 8'd0);
        chk("rst_valid", {7'd0, qp_valid}, 8'd0);
        chk("rst_ready", {7'd0, mb_ready}, 8'd1);
        chk("rst_err", {7'd0, delta_err}, 8'd0);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        reset = 1'b0;
        tick();

        // MB before any slice uses predictor 26
        mb_to_hold(1'b0, 7'd5);
        hold_chk("pre_slice", 6'd26, 6'd26);

        // Latency walk: 28 + 2 = 30, chroma 29
        new_slice(6'd28, 5'd0);
        mb_has_delta = 1'b1;
        mb_qp_delta  = 7'd2;
        mb_valid     = 1'b1;
        tick();
        mb_valid = 1'b0;
        chk("c1_busy", {7'd0, busy}, 8'd1);
        chk("c1_ready", {7'd0, mb_ready}, 8'd0);
        chk("c1_valid", {7'd0, qp_valid}, 8'd0);
        tick();
        chk("c2_qpy", {2'd0, QPy}, 8'd30);
        chk("c2_valid", {7'd0, qp_valid}, 8'd0);
        tick();
        hold_chk("c3", 6'd30, 6'd29);
        chk("c4_ready", {7'd0, mb_ready}, 8'd1);
        chk("c4_valid", {7'd0, qp_valid}, 8'd0);
        chk("c4_busy", {7'd0, busy}, 8'd0);

        // Wrap: 50+5 -> 3, then 3-10 -> 45 (chroma 38)
        new_slice(6'd50, 5'd0);
        mb_to_hold(1'b1, 7'd5);
        hold_chk("wrap_hi", 6'd3, 6'd3);
        mb_to_hold(1'b1, 7'h76);
        hold_chk("wrap_lo", 6'd45, 6'd38);

        // Legal delta extremes: 26+25 -> 51, 51-26 -> 25
        new_slice(6'd26, 5'd0);
        mb_to_hold(1'b1, 7'd25);
        hold_chk("d_max", 6'd51, 6'd39);
        mb_to_hold(1'b1, 7'h66);
        hold_chk("d_min", 6'd25, 6'd25);
        chk("d_edge_err", {7'd0, delta_err}, 8'd0);

        // Chroma clip: 5-12 -> 0, 51+12 -> 51 -> 39
        new_slice(6'd5, 5'b10100);
        mb_to_hold(1'b0, 7'd0);
        hold_chk("clip_lo", 6'd5, 6'd0);
        new_slice(6'd51, 5'd12);
        mb_to_hold(1'b0, 7'd0);
        hold_chk("clip_hi", 6'd51, 6'd39);

        // Backpressure for 6 cycles
        new_slice(6'd28, 5'd0);
        qp_ready = 1'b0;
        mb_to_hold(1'b1, 7'd2);
        for (int i = 0; i < 6; i++) begin
            chk("bp_valid", {7'd0, qp_valid}, 8'd1);
            chk("bp_qpy", {2'd0, QPy}, 8'd30);
            chk("bp_cb", {2'd0, QPc_cb}, 8'd29);
            chk("bp_ready", {7'd0, mb_ready}, 8'd0);
            tick();
        end
        qp_ready = 1'b1;
        tick();
        chk("bp_rel_ready", {7'd0, mb_ready}, 8'd1);
        chk("bp_rel_valid", {7'd0, qp_valid}, 8'd0);

        // Illegal deltas +30 and -27 keep predictor 20
        new_slice(6'd20, 5'd0);
        chk("ill_err0", {7'd0, delta_err}, 8'd0);
        mb_to_hold(1'b1, 7'd30);
        chk("ill_err1", {7'd0, delta_err}, 8'd1);
        hold_chk("ill_pos", 6'd20, 6'd20);
        mb_to_hold(1'b1, 7'h65);
        hold_chk("ill_neg", 6'd20, 6'd20);
        chk("ill_err2", {7'd0, delta_err}, 8'd1);

        // slice_start with mb_valid: not accepted, error cleared
        slice_qp     = 6'd33;
        slice_start  = 1'b1;
        mb_valid     = 1'b1;
        mb_has_delta = 1'b1;
        mb_qp_delta  = 7'd1;
        tick();
        slice_start = 1'b0;
        mb_valid    = 1'b0;
        chk("ss_busy", {7'd0, busy}, 8'd0);
        chk("ss_ready", {7'd0, mb_ready}, 8'd1);
        chk("ss_err", {7'd0, delta_err}, 8'd0);
        mb_to_hold(1'b0, 7'd0);
        hold_chk("ss_pred", 6'd33, 6'd32);

        // slice_start while in MAP discards the MB
        mb_has_delta = 1'b1;
        mb_qp_delta  = 7'd1;
        mb_valid     = 1'b1;
        tick();
        mb_valid = 1'b0;
        tick();
        slice_qp    = 6'd10;
        slice_start = 1'b1;
        tick();
        slice_start = 1'b0;
        chk("map_ss_busy", {7'd0, busy}, 8'd0);
        chk("map_ss_ready", {7'd0, mb_ready}, 8'd1);
        for (int i = 0; i < 4; i++) begin
            chk("map_ss_valid", {7'd0, qp_valid}, 8'd0);
            tick();
        end
        mb_to_hold(1'b0, 7'd0);
        hold_chk("map_ss_pred", 6'd10, 6'd10);

`ifdef QP_SECOND_CHROMA_OFFSET_EN
        // Independent Cr: 40 -> Cb 36, Cr qPI 36 -> 34
        new_slice(6'd40, 5'd0);
        cr_off = 5'b11100;
        mb_to_hold(1'b0, 7'd0);
        chk("cr_qpy", {2'd0, QPy}, 8'd40);
        chk("cr_cb", {2'd0, QPc_cb}, 8'd36);
        chk("cr_cr", {2'd0, QPc_cr}, 8'd34);
        tick();
        cr_off = 5'd0;
`endif

        // Asynchronous reset while in MAP
        mb_to_hold(1'b1, 7'd1);
        hold_chk("pre_arst", QPy, QPc_cb);
        mb_has_delta = 1'b1;
        mb_qp_delta  = 7'd3;
        mb_valid     = 1'b1;
        tick();
        mb_valid = 1'b0;
        tick();
        #2;
        reset = 1'b1;
        #1;
        chk("arst_qpy", {2'd0, QPy}, 8'd0);
        chk("arst_cb", {2'd0, QPc_cb}, 8'd0);
        chk("arst_busy", {7'd0, busy}, 8'd0);
        chk("arst_ready", {7'd0, mb_ready}, 8'd1);
        #2;
        reset = 1'b0;
        tick();
        mb_to_hold(1'b0, 7'd0);
        hold_chk("arst_pred", 6'd26, 6'd26);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
